alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter W, default 32, datapath width in bits; legal values 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(W), width of the shift-amount field taken from a.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present on op/a/b.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  4  operation: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR, 7 SLL, 8 SRL, 9 SRA, 10 SLT, 11 MUL, 12 DIV, 13-15 reserved.
REQ-008 a  input  W  operand A, signed two's complement; shift amount is a[SHW-1:0].
REQ-009 b  input  W  operand B, signed two's complement; value shifted for SLL/SRL/SRA.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 result  output  W  primary result (MUL low half, DIV quotient).
REQ-013 hi  output  W  MUL high half, DIV remainder; zero for all other ops.
REQ-014 less, equal, greater  output  1 each  signed compare of a vs b, valid for SUB and SLT only, else 0.
REQ-015 overflow  output  1  signed overflow for ADD, SUB, and DIV of (MIN / -1); else 0.
REQ-016 div_zero  output  1  DIV with b == 0.

Function
REQ-017 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE and not in reset.
REQ-018 Request accepted when in_valid && in_ready; op, a, b SHALL be captured that cycle.
REQ-019 Ops 0-10 and reserved ops: IDLE -> DONE, out_valid asserted the cycle after acceptance (latency 1).
REQ-020 MUL/DIV: IDLE -> CALC, iterate exactly W cycles (one bit per cycle), then DONE; out_valid first asserted W+1 cycles after acceptance.
REQ-021 DONE: result and flags held stable while out_valid && !out_ready; on out_ready transition to IDLE, out_valid deasserts next cycle.
REQ-022 No new request accepted in DONE, even if out_ready is high that cycle (one-cycle bubble between operations).
REQ-023 ADD/SUB wrap modulo 2^W; overflow = operand signs as for add (B negated for SUB) agree and result sign differs.
REQ-024 SLL/SRL logical shift of b by a[SHW-1:0]; SRA arithmetic; upper bits of a ignored.
REQ-025 SLT: result = 1 if signed a < b else 0.
REQ-026 NOP and reserved ops: result = 0, hi = 0, all flags 0.
REQ-027 MUL: signed W x W -> 2W product, {hi, result}.
REQ-028 DIV: signed, quotient truncates toward zero, remainder has sign of a.
REQ-029 DIV by zero: completes with latency 1 (no CALC), result = all ones, hi = a, div_zero = 1.
REQ-030 DIV MIN / -1: result = MIN, hi = 0, overflow = 1, normal W-cycle latency.
REQ-031 Inputs changing after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-032 rst high at any clock edge, including mid-CALC or in DONE: state -> IDLE, in-flight operation discarded, no out_valid for it.
REQ-033 Reset values: out_valid 0, result 0, hi 0, all flags 0; in_ready 0 while rst high, 1 the first cycle after.

Configuration
REQ-034 Macro ALU_MC_MULDIV_EN: defined -> MUL/DIV behave per REQ-020, 027-030.
REQ-035 Undefined -> MUL/DIV treated as reserved (REQ-019, REQ-026), CALC state and iterative datapath not synthesised.

Verification
REQ-036 W=32, ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow 1, out_valid one cycle after accept.
REQ-037 SUB a=-5 b=3 -> result -8, less 1, equal 0, greater 0; SLT same operands -> result 1.
REQ-038 SRA b=0x80000000 a=0x00000024 (amount 4) -> result 0xF8000000; SRL same -> 0x08000000.
REQ-039 MUL a=-3 b=7 -> {hi,result} = 0xFFFFFFFF_FFFFFFEB, out_valid exactly 33 cycles after accept; out_ready held low 5 cycles -> outputs stable, in_ready 0.
REQ-040 DIV a=-7 b=2 -> result -3, hi -1; DIV a=5 b=0 -> result 0xFFFFFFFF, hi 5, div_zero 1, latency 1.
REQ-041 DIV a=100 b=3, assert rst at cycle 10 of CALC -> no out_valid, in_ready 1 the cycle after rst drops; macro undefined -> MUL 6*7 returns result 0 latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready handshake and an IDLE/CALC/DONE FSM.
// Define ALU_MC_MULDIV_EN to build the iterative signed MUL/DIV; otherwise MUL/DIV act as reserved ops.
module alu_mc #(
  parameter int W   = 32,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [W-1:0] hi,
  output logic         less,
  output logic         equal,
  output logic         greater,
  output logic         overflow,
  output logic         div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] result_q, result_d, hi_q, hi_d;
  logic [4:0] flags_q, flags_d;
  logic accept, go_calc, calc_last;
  logic [W-1:0] sum, diff, alu_res, alu_hi, md_res, md_hi;
  logic [4:0] alu_flags;
  logic add_ovf, sub_ovf, lt, eq, md_ovf;
  logic [SHW-1:0] shamt;
  assign accept  = in_valid && in_ready;
  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  assign sub_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
  assign lt      = $signed(a) < $signed(b);
  assign eq      = a == b;
  assign shamt   = a[SHW-1:0];
  // Single-cycle ops evaluated straight from the request so nothing but the result is stored.
  always_comb begin
    alu_res   = '0;
    alu_hi    = '0;
    alu_flags = '0;
    case (op)
      4'd1: begin
        alu_res   = sum;
        alu_flags = {3'b000, add_ovf, 1'b0};
      end
      4'd2: begin
        alu_res   = diff;
        alu_flags = {lt, eq, !lt && !eq, sub_ovf, 1'b0};
      end
      4'd3: alu_res = a & b;
      4'd4: alu_res = a | b;
      4'd5: alu_res = a ^ b;
      4'd6: alu_res = ~(a | b);
      4'd7: alu_res = b << shamt;
      4'd8: alu_res = b >> shamt;
      4'd9: alu_res = W'($signed(b) >>> shamt);
      4'd10: begin
        alu_res   = {{(W-1){1'b0}}, lt};
        alu_flags = {lt, eq, !lt && !eq, 2'b00};
      end
`ifdef ALU_MC_MULDIV_EN
      4'd12: begin
        if (b == '0) begin
          alu_res   = '1;
          alu_hi    = a;
          alu_flags = 5'b00001;
        end
      end
`endif
      default: alu_res = '0;
    endcase
  end
`ifdef ALU_MC_MULDIV_EN
  logic [W:0] acc_hi_q, acc_hi_d, shifted, msum, nhi;
  logic [W-1:0] acc_lo_q, acc_lo_d, opnd_q, opnd_d, nlo, abs_a, abs_b;
  logic [2*W-1:0] prod, sprod;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, ovf_q, ovf_d, ge;
  assign go_calc   = (op == 4'd11) || (op == 4'd12 && b != '0);
  assign calc_last = &cnt_q;
  assign abs_a     = a[W-1] ? -a : a;
  assign abs_b     = b[W-1] ? -b : b;
  // Unsigned magnitude datapath: shift-add multiply or restoring divide, one bit per cycle.
  assign shifted = {acc_hi_q[W-1:0], acc_lo_q[W-1]};
  assign ge      = shifted >= {1'b0, opnd_q};
  assign msum    = acc_hi_q + {1'b0, acc_lo_q[0] ? opnd_q : {W{1'b0}}};
  assign nhi     = is_div_q ? (ge ? shifted - {1'b0, opnd_q} : shifted) : {1'b0, msum[W:1]};
  assign nlo     = is_div_q ? {acc_lo_q[W-2:0], ge} : {msum[0], acc_lo_q[W-1:1]};
  assign prod    = {nhi[W-1:0], nlo};
  assign sprod   = neg_q ? -prod : prod;
  assign md_res  = is_div_q ? (neg_q ? -nlo : nlo) : sprod[W-1:0];
  assign md_hi   = is_div_q ? (rneg_q ? -nhi[W-1:0] : nhi[W-1:0]) : sprod[2*W-1:W];
  assign md_ovf  = ovf_q;
  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    ovf_d    = ovf_q;
    if (accept && go_calc) begin
      acc_hi_d = '0;
      acc_lo_d = op == 4'd12 ? abs_a : abs_b;
      opnd_d   = op == 4'd12 ? abs_b : abs_a;
      cnt_d    = '0;
      is_div_d = op == 4'd12;
      neg_d    = a[W-1] ^ b[W-1];
      rneg_d   = a[W-1];
      ovf_d    = op == 4'd12 && a == {1'b1, {(W-1){1'b0}}} && &b;
    end else if (state_q == CALC) begin
      acc_hi_d = nhi;
      acc_lo_d = nlo;
      cnt_d    = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      ovf_q    <= ovf_d;
    end
  end
`else
  assign go_calc   = 1'b0;
  assign calc_last = 1'b0;
  assign md_res    = '0;
  assign md_hi     = '0;
  assign md_ovf    = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? (go_calc ? CALC : DONE) : IDLE;
      CALC:    state_d = calc_last ? DONE : CALC;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state_q == IDLE && !rst;
    out_valid = state_q == DONE;
  end
  always_comb begin
    result_d = result_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    if (accept && !go_calc) begin
      result_d = alu_res;
      hi_d     = alu_hi;
      flags_d  = alu_flags;
    end else if (state_q == CALC && calc_last) begin
      result_d = md_res;
      hi_d     = md_hi;
      flags_d  = {3'b000, md_ovf, 1'b0};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
    end
  end
  assign result = result_q;
  assign hi     = hi_q;
  assign {less, equal, greater, overflow, div_zero} = flags_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: vector table plus scoreboard for alu_mc (W=32), with handshake, backpressure and reset sequences.
module tb_alu_mc;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [3:0] op = 0;
  logic [31:0] a = 0, b = 0, result, hi;
  logic less, equal, greater, overflow, div_zero;
  int pass_cnt = 0, total_cnt = 0;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res, hi;
    logic [4:0]  fl;
    int          lat;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  alu_mc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .hi(hi), .less(less),
    .equal(equal), .greater(greater), .overflow(overflow), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
    else pass_cnt++;
  endtask
  // Issue one request, scramble inputs after acceptance, and compare against the scoreboard head.
  task automatic run(input vec_t v, input bit ack);
    vec_t e;
    int lat;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    chk("in_ready_before_issue", in_ready, 1);
    op = v.op;
    a = v.a;
    b = v.b;
    in_valid = 1;
    sb.push_back(v);
    @(posedge clk);
    #1;
    in_valid = 0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
    lat = 0;
    for (int i = 0; i < 100 && !(lat > 0 && out_valid); i++) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk($sformatf("lat_op%0d", e.op), lat, e.lat);
    chk($sformatf("result_op%0d", e.op), result, e.res);
    chk($sformatf("hi_op%0d", e.op), hi, e.hi);
    chk($sformatf("flags_op%0d", e.op), {less, equal, greater, overflow, div_zero}, e.fl);
    if (ack) begin
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
    end
  endtask
  initial begin
    vec_t v;
    bit seen;
    vecs.push_back('{4'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 5'b00010, 1});
    vecs.push_back('{4'd1,  32'h00000001, 32'h00000002, 32'h00000003, 32'h0, 5'b00000, 1});
    vecs.push_back('{4'd2,  32'hFFFFFFFB, 32'h00000003, 32'hFFFFFFF8, 32'h0, 5'b10000, 1});
    vecs.push_back('{4'd10, 32'hFFFFFFFB, 32'h00000003, 32'h00000001, 32'h0, 5'b10000, 1});
    vecs.push_back('{4'd2,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 5'b10010, 1});
    vecs.push_back('{4'd2,  32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 5'b01000, 1});
    vecs.push_back('{4'd2,  32'h00000003, 32'hFFFFFFFB, 32'h00000008, 32'h0, 5'b00100, 1});
    vecs.push_back('{4'd10, 32'h00000003, 32'hFFFFFFFB, 32'h00000000, 32'h0, 5'b00100, 1});
    vecs.push_back('{4'd9,  32'h00000024, 32'h80000000, 32'hF8000000, 32'h0, 5'b00000, 1});
    vecs.push_back('{4'd8,  32'h00000024, 32'h80000000, 32'h08000000, 32'h0, 5'b00000, 1});
    vecs.push_back('{4'd7,  32'hFFFFFF23, 32'h00000001, 32'h00000008, 32'h0, 5'b00000, 1});
    vecs.push_back('{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 5'b00000, 1});
    vecs.push_back('{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0, 5'b00000, 1});
    vecs.push_back('{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 5'b00000, 1});
    vecs.push_back('{4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'h0, 5'b00000, 1});
    vecs.push_back('{4'd0,  32'h00000001, 32'h00000002, 32'h00000000, 32'h0, 5'b00000, 1});
    vecs.push_back('{4'd13, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 5'b00000, 1});
`ifdef ALU_MC_MULDIV_EN
    vecs.push_back('{4'd11, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 5'b00000, 33});
    vecs.push_back('{4'd11, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 5'b00000, 33});
    vecs.push_back('{4'd12, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 5'b00000, 33});
    vecs.push_back('{4'd12, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 5'b00000, 33});
    vecs.push_back('{4'd12, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 5'b00001, 1});
    vecs.push_back('{4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 5'b00010, 33});
`else
    vecs.push_back('{4'd11, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0, 5'b00000, 1});
    vecs.push_back('{4'd12, 32'h00000005, 32'h00000000, 32'h00000000, 32'h0, 5'b00000, 1});
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {result, hi, less, equal, greater, overflow, div_zero}, 0);
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    foreach (vecs[i]) run(vecs[i], 1);
    // Backpressure: hold out_ready low, outputs must not move and no new request may enter.
`ifdef ALU_MC_MULDIV_EN
    v = '{4'd11, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 5'b00000, 33};
`else
    v = '{4'd1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 5'b00010, 1};
`endif
    run(v, 0);
    in_valid = 1;
    op = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_data", {result, hi}, {v.res, v.hi});
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    @(negedge clk);
    chk("bubble_out_valid", out_valid, 0);
    chk("bubble_in_ready", in_ready, 1);
    in_valid = 0;
    // Reset while a result waits in DONE.
    run('{4'd1, 32'h00000010, 32'h00000020, 32'h00000030, 32'h0, 5'b00000, 1}, 0);
    rst = 1;
    @(negedge clk);
    chk("done_rst_out_valid", out_valid, 0);
    chk("done_rst_in_ready", in_ready, 0);
    chk("done_rst_result", result, 0);
    rst = 0;
    #1;
    chk("done_rst_release_ready", in_ready, 1);
`ifdef ALU_MC_MULDIV_EN
    // Reset in the middle of a DIV: the operation must vanish.
    @(negedge clk);
    op = 4'd12;
    a = 32'd100;
    b = 32'd3;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("calc_rst_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("calc_rst_no_valid", seen, 0);
    chk("calc_rst_result", result, 0);
`endif
    run('{4'd1, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 5'b00000, 1}, 1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
